// File: rtl/kdtree_pkg.sv
// kdtree_pkg: shared constants, node-table entry type and element-select helper
// for the KD-tree search pipeline.
//   DEF_NUM_DIMS   - default number of elements per patch
//   DEF_ELEM_WIDTH - default bits per signed element
//   DIM_W          - width of the split-dimension field
//   node_entry_t   - {valid, dim, median} entry held per tree node
//   slice_dim()    - returns element 'dim' of a patch (dim 0 = MSB slice)
package kdtree_pkg;

  localparam int DEF_NUM_DIMS   = 5;
  localparam int DEF_ELEM_WIDTH = 11;
  localparam int DIM_W          = 3;

  typedef struct packed {
    logic                             valid;
    logic [DIM_W-1:0]                 dim;
    logic signed [DEF_ELEM_WIDTH-1:0] median;
  } node_entry_t;

  // Out-of-range dims return 0; callers flag those entries as errors and
  // never use the compare result.
  function automatic logic signed [DEF_ELEM_WIDTH-1:0] slice_dim(
    input logic [DEF_NUM_DIMS*DEF_ELEM_WIDTH-1:0] patch,
    input logic [DIM_W-1:0]                       dim
  );
    logic signed [DEF_ELEM_WIDTH-1:0] s;
    s = '0;
    for (int d = 0; d < DEF_NUM_DIMS; d++) begin
      if (dim == DIM_W'(d)) begin
        s = patch[(DEF_NUM_DIMS-d)*DEF_ELEM_WIDTH-1 -: DEF_ELEM_WIDTH];
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/kdtree_level_stage_node_table.sv
// kdtree_node_table: N-entry register file of KD-tree node entries.
//   clk, rst_n   - clock, synchronous active-low reset (clears every entry)
//   wen, waddr   - synchronous write strobe and target node
//   wdim, wmedian- split dimension and signed median to store
//   raddr        - asynchronous read address
//   rentry       - entry at raddr; all-zero (invalid) when raddr >= N
module kdtree_node_table
  import kdtree_pkg::*;
#(
  parameter int N      = 1,
  parameter int ADDR_W = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DIM_W-1:0]          wdim,
  input  logic [DEF_ELEM_WIDTH-1:0] wmedian,
  input  logic [ADDR_W-1:0]         raddr,
  output node_entry_t               rentry
);

  node_entry_t mem_r [N];

  // Table storage: reset clears all entries, a write marks the entry valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wen && (waddr == ADDR_W'(i))) begin
          mem_r[i] <= '{valid: 1'b1, dim: wdim, median: wmedian};
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // Asynchronous read port; unmatched addresses read as an unconfigured node.
  always_comb begin
    rentry = '0;
    for (int i = 0; i < N; i++) begin
      rentry = (raddr == ADDR_W'(i)) ? mem_r[i] : rentry;
    end
  end

endmodule

// File: rtl/kdtree_level_stage.sv
// kdtree_level_stage: one level of the pipelined KD-tree search path.
// Looks up the node reached by an incoming patch, compares the selected
// element against the node median and forwards the patch with the child
// address {node, go_right} through a single valid/ready output register.
//   clk, rst_n                     - clock, synchronous active-low reset
//   cfg_wen/addr/dim/median        - node-table write port
//   in_valid/in_ready/in_patch/in_addr  - upstream handshake and payload
//   out_valid/out_ready/out_patch/out_addr/out_err - downstream side
//   err_count                      - saturating count of errored transfers
module kdtree_level_stage
  import kdtree_pkg::*;
#(
  parameter int NUM_DIMS   = DEF_NUM_DIMS,
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int LEVEL      = 0,
  parameter int ADDR_W     = (LEVEL > 0) ? LEVEL : 1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_wen,
  input  logic [ADDR_W-1:0]              cfg_addr,
  input  logic [2:0]                     cfg_dim,
  input  logic [ELEM_WIDTH-1:0]          cfg_median,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_DIMS*ELEM_WIDTH-1:0] in_patch,
  input  logic [ADDR_W-1:0]              in_addr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_DIMS*ELEM_WIDTH-1:0] out_patch,
  output logic [LEVEL:0]                 out_addr,
  output logic                           out_err,
  output logic [ERR_CNT_W-1:0]           err_count
);

  localparam int N     = 1 << LEVEL;
  localparam int OUT_W = LEVEL + 1;

  logic [ADDR_W-1:0]            node_s;
  node_entry_t                  entry_s;
  logic signed [ELEM_WIDTH-1:0] slice_s;
  logic                         err_s;
  logic                         go_right_s;
  logic [OUT_W-1:0]             next_addr_s;
  logic                         accept_s;

  // The root level has a single node, so the incoming address is ignored.
  assign node_s = (LEVEL == 0) ? ADDR_W'(0) : in_addr;

  kdtree_node_table #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wen     (cfg_wen),
    .waddr   (cfg_addr),
    .wdim    (cfg_dim),
    .wmedian (cfg_median),
    .raddr   (node_s),
    .rentry  (entry_s)
  );

  // in_ready looks only at the output register and out_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;

  // Split decision: equality goes right; bad entries force left and flag.
  always_comb begin
    slice_s     = slice_dim(in_patch, entry_s.dim);
    err_s       = !entry_s.valid || (entry_s.dim >= DIM_W'(NUM_DIMS));
    go_right_s  = 1'b0;
    if (err_s) begin
      go_right_s = 1'b0;
    end else begin
      go_right_s = !(slice_s < $signed(entry_s.median));
    end
    next_addr_s = OUT_W'({node_s, go_right_s});
  end

  // Output register: load on accept, drain on transfer, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_patch <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_patch <= in_patch;
      out_addr  <= next_addr_s;
      out_err   <= err_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_patch <= out_patch;
      out_addr  <= out_addr;
      out_err   <= out_err;
    end else begin
      out_valid <= out_valid;
      out_patch <= out_patch;
      out_addr  <= out_addr;
      out_err   <= out_err;
    end
  end

  // Error counter: counts errored output transfers, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end else begin
      err_count <= err_count;
    end
  end

endmodule

// File: tb/tb_kdtree_level_stage.sv
// Self-checking bench for kdtree_level_stage: a LEVEL=0 instance driven with
// directed routing/same-cycle-config steps, and a LEVEL=2 (ERR_CNT_W=2)
// instance checked every cycle against a queue-based reference model.
module tb_kdtree_level_stage;

  localparam int ND = 5;
  localparam int EW = 11;
  localparam int PW = ND * EW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // LEVEL=0 instance
  logic          cfg_wen0, in_valid0, in_ready0, out_valid0, out_ready0, out_err0;
  logic [0:0]    cfg_addr0, in_addr0, out_addr0;
  logic [2:0]    cfg_dim0;
  logic [EW-1:0] cfg_median0;
  logic [PW-1:0] in_patch0, out_patch0;
  logic [15:0]   err_count0;

  // LEVEL=2 instance
  logic          cfg_wen2, in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
  logic [1:0]    cfg_addr2, in_addr2, err_count2;
  logic [2:0]    cfg_dim2, out_addr2;
  logic [EW-1:0] cfg_median2;
  logic [PW-1:0] in_patch2, out_patch2;

  kdtree_level_stage #(.LEVEL(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cfg_wen(cfg_wen0), .cfg_addr(cfg_addr0), .cfg_dim(cfg_dim0), .cfg_median(cfg_median0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_patch(in_patch0), .in_addr(in_addr0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_patch(out_patch0),
    .out_addr(out_addr0), .out_err(out_err0), .err_count(err_count0)
  );

  kdtree_level_stage #(.LEVEL(2), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_wen(cfg_wen2), .cfg_addr(cfg_addr2), .cfg_dim(cfg_dim2), .cfg_median(cfg_median2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_patch(in_patch2), .in_addr(in_addr2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_patch(out_patch2),
    .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model for the LEVEL=2 instance ----------------
  typedef struct {
    logic [PW-1:0] patch;
    int            addr;
    bit            err;
  } exp_t;

  bit   m_valid [4];
  int   m_dim   [4];
  int   m_med   [4];
  exp_t q [$];
  int   m_cnt;
  bit   last_fin;

  function automatic int to_int11(input logic [EW-1:0] b);
    int v;
    v = int'(b);
    if (v >= 1024) v -= 2048;
    return v;
  endfunction

  function automatic int elem_of(input logic [PW-1:0] p, input int d);
    logic [PW-1:0] s;
    s = p >> ((ND - 1 - d) * EW);
    return to_int11(s[EW-1:0]);
  endfunction

  function automatic logic [PW-1:0] mk_patch(input int e [ND]);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < ND; i++) p = (p << EW) | PW'(e[i] & 32'h7FF);
    return p;
  endfunction

  function automatic logic [PW-1:0] rnd_patch();
    int e [ND];
    for (int i = 0; i < ND; i++) e[i] = int'($urandom_range(0, 2047));
    return mk_patch(e);
  endfunction

  function automatic exp_t predict(input logic [PW-1:0] p, input int node);
    exp_t e;
    bit   go;
    e.patch = p;
    e.err   = !m_valid[node] || (m_dim[node] >= ND);
    go      = 1'b0;
    if (!e.err) go = (elem_of(p, m_dim[node]) >= m_med[node]);
    e.addr  = node * 2 + (go ? 1 : 0);
    return e;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dim[i]   = 0;
      m_med[i]   = 0;
    end
  endfunction

  // Called at a negedge with inputs already driven; checks, models one edge.
  task automatic step2();
    exp_t e;
    bit   fin, fout;
    #1;
    chk("in_ready", in_ready2, (q.size() == 0) || out_ready2);
    chk("out_valid", out_valid2, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_patch", out_patch2, q[0].patch);
      chk("out_addr", out_addr2, q[0].addr);
      chk("out_err", out_err2, q[0].err);
    end
    chk("err_count", err_count2, m_cnt);
    last_fin = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      fout = (q.size() != 0) && out_ready2;
      fin  = in_valid2 && ((q.size() == 0) || out_ready2);
      e    = predict(in_patch2, int'(in_addr2));
      if (fout) begin
        if (q[0].err && m_cnt < 3) m_cnt++;
        void'(q.pop_front());
      end
      if (fin) q.push_back(e);
      last_fin = fin;
      if (cfg_wen2) begin
        m_valid[cfg_addr2] = 1'b1;
        m_dim[cfg_addr2]   = int'(cfg_dim2);
        m_med[cfg_addr2]   = to_int11(cfg_median2);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- LEVEL=0 helpers ----------------
  task automatic cfg0(input int dim, input int med);
    cfg_wen0 = 1'b1; cfg_addr0 = 1'b0; cfg_dim0 = 3'(dim); cfg_median0 = EW'(med);
    @(negedge clk);
    cfg_wen0 = 1'b0;
  endtask

  task automatic send0(input string tag, input int slice2, input logic exp_addr);
    int e [ND];
    logic [PW-1:0] p;
    for (int i = 0; i < ND; i++) e[i] = int'($urandom_range(0, 2047));
    e[2] = slice2;
    p = mk_patch(e);
    in_valid0 = 1'b1; in_patch0 = p;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0; cfg_wen0 = 1'b0;
    chk({tag, "_valid"}, out_valid0, 1'b1);
    chk({tag, "_addr"}, out_addr0, exp_addr);
    chk({tag, "_err"}, out_err0, 1'b0);
    chk({tag, "_patch"}, out_patch0, p);
    @(negedge clk);
  endtask

  initial begin
    logic [PW-1:0] pats [4];
    int e [ND];
    int pi, n, d;

    rst_n = 1'b0;
    cfg_wen0 = 1'b0; cfg_addr0 = '0; cfg_dim0 = '0; cfg_median0 = '0;
    in_valid0 = 1'b0; in_patch0 = '0; in_addr0 = '0; out_ready0 = 1'b1;
    cfg_wen2 = 1'b0; cfg_addr2 = '0; cfg_dim2 = '0; cfg_median2 = '0;
    in_valid2 = 1'b0; in_patch2 = '0; in_addr2 = '0; out_ready2 = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_in_ready0", in_ready0, 1'b1);
    chk("rst_out_valid0", out_valid0, 1'b0);
    chk("rst_out_patch0", out_patch0, '0);
    chk("rst_out_addr0", out_addr0, '0);
    chk("rst_out_err0", out_err0, 1'b0);
    chk("rst_err_count0", err_count0, '0);
    chk("rst_in_ready2", in_ready2, 1'b1);
    chk("rst_out_valid2", out_valid2, 1'b0);
    chk("rst_err_count2", err_count2, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // LEVEL=0 routing around median 100 on dim 2
    cfg0(2, 100);
    send0("l0_99", 99, 1'b0);
    send0("l0_100", 100, 1'b1);
    send0("l0_m5", -5, 1'b0);
    send0("l0_max", 1023, 1'b1);
    send0("l0_min", -1024, 1'b0);

    // Same-cycle write and lookup of node 0 uses the old entry
    cfg0(2, 0);
    cfg_wen0 = 1'b1; cfg_addr0 = 1'b0; cfg_dim0 = 3'd2; cfg_median0 = 11'd50;
    send0("same_cyc_old", 20, 1'b1);
    send0("same_cyc_new", 20, 1'b0);
    chk("l0_err_count", err_count0, 16'd0);

    // LEVEL=2: unconfigured node -> error, address {01,0}
    in_valid2 = 1'b1; in_addr2 = 2'd1; in_patch2 = rnd_patch();
    step2();
    in_valid2 = 1'b0;
    chk("unconf_addr", out_addr2, 3'b010);
    chk("unconf_err", out_err2, 1'b1);
    step2();
    step2();
    chk("unconf_count", err_count2, 2'd1);

    // LEVEL=2: node 1 dim 4 median -3
    cfg_wen2 = 1'b1; cfg_addr2 = 2'd1; cfg_dim2 = 3'd4; cfg_median2 = 11'h7FD;
    step2();
    cfg_wen2 = 1'b0;
    for (int i = 0; i < ND; i++) e[i] = int'($urandom_range(0, 2047));
    e[4] = -4;
    in_valid2 = 1'b1; in_addr2 = 2'd1; in_patch2 = mk_patch(e);
    step2();
    chk("n1_m4_addr", out_addr2, 3'b010);
    e[4] = -3;
    in_patch2 = mk_patch(e);
    step2();
    chk("n1_m3_addr", out_addr2, 3'b011);
    chk("n1_m3_err", out_err2, 1'b0);
    in_valid2 = 1'b0;
    step2();

    // Configure all nodes, then backpressure with 4 patches
    for (int k = 0; k < 4; k++) begin
      cfg_wen2 = 1'b1; cfg_addr2 = 2'(k); cfg_dim2 = 3'($urandom_range(0, 4));
      cfg_median2 = 11'($urandom_range(0, 2047));
      step2();
    end
    cfg_wen2 = 1'b0;
    for (int k = 0; k < 4; k++) pats[k] = rnd_patch();
    pi = 0;
    n  = 0;
    while ((pi < 4 || q.size() != 0) && n < 20) begin
      in_valid2  = (pi < 4);
      in_patch2  = pats[pi % 4];
      in_addr2   = 2'(pi);
      out_ready2 = !(n >= 1 && n <= 3);
      step2();
      if (last_fin) pi++;
      n++;
    end
    chk("bp_all_sent", pi, 4);
    chk("bp_drained", q.size(), 0);
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    step2();

    // Randomized traffic with live reconfiguration
    for (int k = 0; k < 400; k++) begin
      cfg_wen2    = ($urandom_range(0, 7) == 0);
      cfg_addr2   = 2'($urandom_range(0, 3));
      cfg_dim2    = 3'($urandom_range(0, 6));
      cfg_median2 = 11'($urandom_range(0, 2047));
      in_valid2   = ($urandom_range(0, 3) != 0);
      out_ready2  = ($urandom_range(0, 3) != 0);
      in_addr2    = 2'($urandom_range(0, 3));
      for (int i = 0; i < ND; i++) e[i] = int'($urandom_range(0, 2047));
      d = m_dim[in_addr2];
      if (d < ND && $urandom_range(0, 1) == 1) e[d] = m_med[in_addr2] + int'($urandom_range(0, 2)) - 1;
      in_patch2 = mk_patch(e);
      step2();
    end
    cfg_wen2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    step2();

    // Saturation of a 2-bit error counter
    rst_n = 1'b0;
    step2();
    rst_n = 1'b1;
    in_valid2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_addr2 = 2'($urandom_range(0, 3)); in_patch2 = rnd_patch();
      step2();
    end
    in_valid2 = 1'b0;
    step2();
    step2();
    chk("sat_count", err_count2, 2'd3);

    // Reset with a stalled output pending
    in_valid2 = 1'b1; in_patch2 = rnd_patch();
    step2();
    in_valid2 = 1'b0; out_ready2 = 1'b0; rst_n = 1'b0;
    step2();
    rst_n = 1'b1;
    chk("mid_rst_valid", out_valid2, 1'b0);
    chk("mid_rst_count", err_count2, 2'd0);
    chk("mid_rst_patch", out_patch2, '0);
    out_ready2 = 1'b1; in_valid2 = 1'b1; in_addr2 = 2'd2; in_patch2 = rnd_patch();
    step2();
    in_valid2 = 1'b0;
    chk("post_rst_unconf_err", out_err2, 1'b1);
    chk("post_rst_unconf_addr", out_addr2, 3'b100);
    step2();
    step2();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kdtree_level_stage.md
# kdtree_level_stage

One full level of the pipelined KD-tree search path. It holds the split dimension and median for all 2**LEVEL nodes of that level and accepts one patch per cycle together with the address of the node it has reached. It compares the selected patch element against that node's median and emits the patch with its child-node address for the next level. Stages are chained LEVEL=0..DEPTH-1; the last stage's address selects a leaf bucket.

## Interface
- NUM_DIMS, 5: elements per patch.
- ELEM_WIDTH, 11: bits per element, signed two's complement.
- LEVEL, 0: tree level; node count N = 2**LEVEL.
- ADDR_W, max(LEVEL,1): node address width at this level.
- ERR_CNT_W, 16: width of the error counter.

- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_wen  in  1  node-table write strobe.
- cfg_addr  in  ADDR_W  node to write.
- cfg_dim  in  3  split dimension, 0..NUM_DIMS-1.
- cfg_median  in  ELEM_WIDTH  signed split value.
- in_valid  in  1  input patch valid.
- in_ready  out  1  stage can accept.
- in_patch  in  NUM_DIMS*ELEM_WIDTH  patch; dim 0 is the MSB slice, dim NUM_DIMS-1 the LSB slice.
- in_addr  in  ADDR_W  node reached at this level; ignored when LEVEL=0 (node 0).
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_patch  out  NUM_DIMS*ELEM_WIDTH  registered copy of in_patch.
- out_addr  out  LEVEL+1  child address = {node, go_right}.
- out_err  out  1  lookup hit an unconfigured or out-of-range node.
- err_count  out  ERR_CNT_W  saturating count of accepted transfers that had out_err=1.

## Operation
- Node table: N entries of {cfg_valid, dim[2:0], median}. Reset clears every cfg_valid; dim and median reset to 0.
- A write with cfg_wen=1 sets cfg_valid=1 and stores dim and median at cfg_addr. A write with cfg_dim ≥ NUM_DIMS is stored as is and is flagged at lookup.
- Lookup on accept (in_valid && in_ready):
  - Read the entry at node (0 when LEVEL=0).
  - slice = in_patch bits [(NUM_DIMS-dim)*ELEM_WIDTH-1 -: ELEM_WIDTH].
  - go_right = !(signed slice < signed median). Equality goes right.
- Error case: the entry is not cfg_valid, or its dim ≥ NUM_DIMS.
  - out_err=1 and go_right=0.
  - The patch still propagates; it is never dropped.
- Handshake: single output register with valid/ready.
  - in_ready = !out_valid || out_ready.
  - A transfer happens on both sides when the condition is true.
  - While out_valid=1 and out_ready=0, out_patch, out_addr and out_err are held stable.
- err_count increments on each output transfer (out_valid && out_ready) with out_err=1. It saturates at all-ones and clears only on reset.
- Simultaneous cfg write and lookup of the same node: the lookup uses the pre-write entry. The new value is visible from the next cycle.
- Reset mid-operation: out_valid drops to 0 the following cycle. In-flight data is discarded. The table is unconfigured.

## Timing
- Reset values: in_ready=1, out_valid=0, out_patch=0, out_addr=0, out_err=0, err_count=0.
- Latency: 1 cycle, accept to out_valid.
- Throughput: 1 patch per cycle with out_ready held high.
- No combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready only.
- cfg writes take effect 1 cycle after the strobe. They are legal at any time, including during traffic.

## Structure
- Package kdtree_pkg holds:
  - The default NUM_DIMS, ELEM_WIDTH and DIM_W=3 constants.
  - The node-entry typedef {valid, dim, median}.
  - A function slice_dim(patch, dim) returning a signed element.
- One sub-module, kdtree_node_table. It is a parametrised N-entry register file with a synchronous write port, an asynchronous read port and reset clearing the valid bits.
- The compare, output register, handshake and error counter live in kdtree_level_stage.

## Test plan
- Reset, no config, LEVEL=2: send any patch with in_addr=1 → out_err=1, out_addr=3'b010. After that transfer completes, err_count=1.
- LEVEL=0: configure node 0 with dim=2, median=100. Send patches with dim-2 slice = 99 → out_addr=1'b0; = 100 → 1'b1; = -5 (11'h7FB) → 1'b0. All with out_err=0.
- LEVEL=1: configure node 1 with dim=4, median=-3. Send patch with LSB slice -4 and in_addr=1 → out_addr=2'b10. Then LSB slice -3 → 2'b11.
- Backpressure: stream 4 patches with out_ready held low for 3 cycles → in_ready=0 while stalled, outputs held stable, no loss or duplication, order preserved.
- Same-cycle cfg write and lookup of node 0: old median 0 → 50, patch slice 20 → routed right (old entry). The next patch with slice 20 is routed left.
- ERR_CNT_W=2: push 5 error transfers → err_count saturates at 3. Then assert rst_n=0 for 1 cycle → err_count=0, out_valid=0, node table unconfigured.
